clk_src_sel_ctrl: RTL and testbench

- Parametrised next-generation clock-source controller in the system clock domain.
- Monitors N synchronised clock-activity flags and picks one source by priority or manual override.
- Drives a glitch-free one-hot select to a BUFGCTRL tree, then sequences reset and lock of the downstream MMCM.
- Adds behaviour the fixed two-input mux lacks:
  - N sources.
  - Holdoff before upgrading to a better source.
  - Lock timeout with per-source failure blacklisting.
  - Switch counting and status.

---
 rtl/clk_src_sel_ctrl_if.sv | 33 +++
 rtl/clk_src_sel_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_clk_src_sel_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_src_sel_ctrl_if.sv
// Signal bundle between the clock-source controller (slave) and the logic that
// feeds it activity/lock flags and consumes its select and status (master).
interface clk_src_sel_ctrl_if #(
    parameter int N_SRC = 4,
    parameter int SEL_W = $clog2(N_SRC),
    parameter int CNT_W = 16
);
    logic [N_SRC-1:0] src_active;
    logic             manual_en;
    logic [SEL_W-1:0] manual_sel;
    logic             clear_fail;
    logic             mmcm_locked;
    logic [N_SRC-1:0] sel_onehot;
    logic [SEL_W-1:0] sel_idx;
    logic             sel_valid;
    logic             mmcm_rst;
    logic             locked_out;
    logic [N_SRC-1:0] fail_mask;
    logic [CNT_W-1:0] switch_count;
    logic [2:0]       state;

    modport master (
        output src_active, manual_en, manual_sel, clear_fail, mmcm_locked,
        input  sel_onehot, sel_idx, sel_valid, mmcm_rst, locked_out,
        input  fail_mask, switch_count, state
    );

    modport slave (
        input  src_active, manual_en, manual_sel, clear_fail, mmcm_locked,
        output sel_onehot, sel_idx, sel_valid, mmcm_rst, locked_out,
        output fail_mask, switch_count, state
    );
endinterface

// File: rtl/clk_src_sel_ctrl.sv
// Clock-source selection controller: picks an eligible source, drives a glitch-free
// one-hot BUFGCTRL select and sequences the downstream MMCM reset and lock.
//
// state     | meaning
// NOSRC     | no eligible source; select idle, MMCM held in reset
// DRAIN     | all selects off for GAP_CYC cycles before a (re)apply
// APPLY     | target select driven, MMCM held in reset for RST_CYC cycles
// WAIT_LOCK | MMCM released, waiting for LOCKED with timeout
// RUN       | locked; watching for source loss, unlock and upgrade
module clk_src_sel_ctrl #(
    parameter int N_SRC        = 4,
    parameter int SEL_W        = $clog2(N_SRC),
    parameter int GAP_CYC      = 4,
    parameter int RST_CYC      = 8,
    parameter int HOLDOFF_CYC  = 256,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    clk_src_sel_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_NOSRC     = 3'd0,
        S_DRAIN     = 3'd1,
        S_APPLY     = 3'd2,
        S_WAIT_LOCK = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    localparam int TMR_MAX = (LOCK_TIMEOUT > GAP_CYC)
                           ? ((LOCK_TIMEOUT > RST_CYC) ? LOCK_TIMEOUT : RST_CYC)
                           : ((GAP_CYC > RST_CYC) ? GAP_CYC : RST_CYC);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int HLD_W   = $clog2(HOLDOFF_CYC + 1);

    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0] RST_LD   = TMR_W'(RST_CYC - 1);
    localparam logic [TMR_W-1:0] LOCK_LD  = TMR_W'(LOCK_TIMEOUT - 1);
    // First candidate cycle arms the timer, so it counts the remaining HOLDOFF_CYC-1
    localparam logic [HLD_W-1:0] HLD_LD   = HLD_W'((HOLDOFF_CYC > 1) ? HOLDOFF_CYC - 2 : 0);
    localparam logic [N_SRC-1:0] ONE_HOT0 = N_SRC'(1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_ld;
    logic [SEL_W-1:0] cur_idx_q, nxt_idx;

    logic [N_SRC-1:0] eligible;
    logic             man_ok, low_found, tgt_valid;
    logic [SEL_W-1:0] low_idx, tgt_idx;
    logic             cur_active, lock_to;

    logic             upg_cand, hold_same, upgrade_go;
    logic             hold_arm_q;
    logic [SEL_W-1:0] hold_tgt_q;
    logic [HLD_W-1:0] hold_tmr_q;

    logic [N_SRC-1:0] sel_q, sel_d, fail_q, fail_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             valid_q, mrst_q, mrst_d, lock_q, lock_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        eligible  = bus.src_active & ~fail_q;
        man_ok    = 1'b0;
        if (bus.manual_en && (int'(bus.manual_sel) < N_SRC))
            man_ok = eligible[bus.manual_sel];
        low_found = 1'b0;
        low_idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                low_found = 1'b1;
                low_idx   = SEL_W'(i);
            end
        end
        tgt_valid = man_ok | low_found;
        tgt_idx   = man_ok ? bus.manual_sel : low_idx;
    end

    assign cur_active = bus.src_active[cur_idx_q];
    assign lock_to    = (state_q == S_WAIT_LOCK) && (tmr_q == '0) && !bus.mmcm_locked;
    assign nxt_idx    = (state_q == S_DRAIN) ? tgt_idx : cur_idx_q;

    assign upg_cand   = (state_q == S_RUN) && tgt_valid && (tgt_idx != cur_idx_q)
                      && ((tgt_idx < cur_idx_q) || man_ok);
    assign hold_same  = hold_arm_q && upg_cand && (tgt_idx == hold_tgt_q);
    assign upgrade_go = upg_cand && (hold_same ? (hold_tmr_q == '0) : (HOLDOFF_CYC == 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_NOSRC;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_NOSRC:
                if (|eligible) state_d = S_DRAIN;
            S_DRAIN:
                if (tmr_q == '0) state_d = tgt_valid ? S_APPLY : S_NOSRC;
            S_APPLY:
                if (!cur_active)        state_d = S_DRAIN;
                else if (tmr_q == '0)   state_d = S_WAIT_LOCK;
            S_WAIT_LOCK:
                if (!cur_active || lock_to) state_d = S_DRAIN;
                else if (bus.mmcm_locked)   state_d = S_RUN;
            S_RUN:
                if (!cur_active)           state_d = S_DRAIN;
                else if (!bus.mmcm_locked) state_d = S_WAIT_LOCK;
                else if (upgrade_go)       state_d = S_DRAIN;
            default:
                state_d = S_NOSRC;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register
    always_comb begin
        sel_d  = '0;
        idx_d  = '0;
        mrst_d = 1'b1;
        lock_d = 1'b0;
        case (state_d)
            S_APPLY: begin
                sel_d = ONE_HOT0 << nxt_idx;
                idx_d = nxt_idx;
            end
            S_WAIT_LOCK: begin
                sel_d  = ONE_HOT0 << nxt_idx;
                idx_d  = nxt_idx;
                mrst_d = 1'b0;
            end
            S_RUN: begin
                sel_d  = ONE_HOT0 << nxt_idx;
                idx_d  = nxt_idx;
                mrst_d = 1'b0;
                lock_d = 1'b1;
            end
            default: ;
        endcase
        fail_d = (fail_q & ~{N_SRC{bus.clear_fail}}) | (lock_to ? (ONE_HOT0 << cur_idx_q) : '0);
        cnt_d  = cnt_q;
        if ((state_d == S_APPLY) && (state_q != S_APPLY) && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_comb begin
        tmr_ld = '0;
        case (state_d)
            S_DRAIN:     tmr_ld = GAP_LD;
            S_APPLY:     tmr_ld = RST_LD;
            S_WAIT_LOCK: tmr_ld = LOCK_LD;
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q     <= '0;
            cur_idx_q <= '0;
        end else begin
            if (state_d != state_q)  tmr_q <= tmr_ld;
            else if (tmr_q != '0)    tmr_q <= tmr_q - TMR_W'(1);
            if (state_d == S_APPLY)  cur_idx_q <= nxt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_arm_q <= 1'b0;
            hold_tgt_q <= '0;
            hold_tmr_q <= '0;
        end else if (!upg_cand) begin
            hold_arm_q <= 1'b0;
        end else if (!hold_same) begin
            hold_arm_q <= 1'b1;
            hold_tgt_q <= tgt_idx;
            hold_tmr_q <= HLD_LD;
        end else if (hold_tmr_q != '0) begin
            hold_tmr_q <= hold_tmr_q - HLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            mrst_q  <= 1'b1;
            lock_q  <= 1'b0;
            fail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            valid_q <= |sel_d;
            mrst_q  <= mrst_d;
            lock_q  <= lock_d;
            fail_q  <= fail_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sel_onehot   = sel_q;
    assign bus.sel_idx      = idx_q;
    assign bus.sel_valid    = valid_q;
    assign bus.mmcm_rst     = mrst_q;
    assign bus.locked_out   = lock_q;
    assign bus.fail_mask    = fail_q;
    assign bus.switch_count = cnt_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_clk_src_sel_ctrl.sv
// Directed bench for clk_src_sel_ctrl: default-parameter instance for sequencing,
// plus a small fast instance for out-of-range manual select and counter saturation.
module tb_clk_src_sel_ctrl;

    localparam logic [2:0] ST_NOSRC = 3'd0, ST_DRAIN = 3'd1, ST_APPLY = 3'd2,
                           ST_WAIT  = 3'd3, ST_RUN   = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    clk_src_sel_ctrl_if #(.N_SRC(4), .SEL_W(2), .CNT_W(16)) bus ();
    clk_src_sel_ctrl_if #(.N_SRC(3), .SEL_W(2), .CNT_W(4))  bus_s ();

    clk_src_sel_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    clk_src_sel_ctrl #(
        .N_SRC(3), .GAP_CYC(1), .RST_CYC(1), .HOLDOFF_CYC(4),
        .LOCK_TIMEOUT(2), .CNT_W(4)
    ) u_dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // select must never move between non-zero values without >= 4 zero samples
    logic [3:0] prev_sel   = '0;
    int         zero_run   = 100;
    int         glitch_err = 0;
    always @(negedge clk) begin
        if ((bus.sel_onehot != 4'b0) && (bus.sel_onehot != prev_sel) && (zero_run < 4))
            glitch_err <= glitch_err + 1;
        zero_run <= (bus.sel_onehot == 4'b0) ? zero_run + 1 : 0;
        prev_sel <= bus.sel_onehot;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev_cnt;
        logic       wrapped;
        logic       set_seen;

        bus.src_active   = '0; bus.manual_en   = 1'b0; bus.manual_sel   = '0;
        bus.clear_fail   = 1'b0; bus.mmcm_locked = 1'b0;
        bus_s.src_active = '0; bus_s.manual_en = 1'b0; bus_s.manual_sel = '0;
        bus_s.clear_fail = 1'b0; bus_s.mmcm_locked = 1'b0;
        tick(3);
        chk("rst_state",    bus.state, ST_NOSRC);
        chk("rst_sel",      bus.sel_onehot, 4'b0);
        chk("rst_idx",      bus.sel_idx, 2'd0);
        chk("rst_valid",    bus.sel_valid, 1'b0);
        chk("rst_mmcm_rst", bus.mmcm_rst, 1'b1);
        chk("rst_locked",   bus.locked_out, 1'b0);
        chk("rst_fail",     bus.fail_mask, 4'b0);
        chk("rst_cnt",      bus.switch_count, 16'd0);

        // power-up on source 2
        bus.src_active = 4'b0100; rst = 1'b0;
        tick(1);  chk("pu_drain",      bus.state, ST_DRAIN);
                  chk("pu_drain_sel",  bus.sel_onehot, 4'b0);
        tick(3);  chk("pu_drain4_sel", bus.sel_onehot, 4'b0);
                  chk("pu_drain4",     bus.state, ST_DRAIN);
        tick(1);  chk("pu_apply",      bus.state, ST_APPLY);
                  chk("pu_apply_sel",  bus.sel_onehot, 4'b0100);
                  chk("pu_apply_idx",  bus.sel_idx, 2'd2);
                  chk("pu_apply_vld",  bus.sel_valid, 1'b1);
                  chk("pu_apply_rst",  bus.mmcm_rst, 1'b1);
                  chk("pu_cnt",        bus.switch_count, 16'd1);
        tick(7);  chk("pu_apply8",     bus.state, ST_APPLY);
                  chk("pu_apply8_rst", bus.mmcm_rst, 1'b1);
        tick(1);  chk("pu_wait",       bus.state, ST_WAIT);
                  chk("pu_wait_rst",   bus.mmcm_rst, 1'b0);
        tick(19); chk("pu_wait20",     bus.state, ST_WAIT);
                  chk("pu_wait20_lk",  bus.locked_out, 1'b0);
        bus.mmcm_locked = 1'b1;
        tick(1);  chk("pu_run",        bus.state, ST_RUN);
                  chk("pu_run_lk",     bus.locked_out, 1'b1);

        // upgrade holdoff: 255 cycles is not enough, 256 is
        bus.src_active = 4'b0101;
        tick(255); chk("upg_short_run", bus.state, ST_RUN);
        bus.src_active = 4'b0100;
        tick(5);   chk("upg_drop_run",  bus.state, ST_RUN);
                   chk("upg_drop_cnt",  bus.switch_count, 16'd1);
        bus.src_active = 4'b0101;
        tick(255); chk("upg_255_run",   bus.state, ST_RUN);
        tick(1);   chk("upg_256_drain", bus.state, ST_DRAIN);
                   chk("upg_drain_sel", bus.sel_onehot, 4'b0);
                   chk("upg_drain_lk",  bus.locked_out, 1'b0);
        bus.mmcm_locked = 1'b0;
        tick(4);   chk("upg_apply_sel", bus.sel_onehot, 4'b0001);
                   chk("upg_apply_idx", bus.sel_idx, 2'd0);
                   chk("upg_cnt",       bus.switch_count, 16'd2);
        tick(8);   chk("upg_wait",      bus.state, ST_WAIT);
        bus.mmcm_locked = 1'b1;
        tick(1);   chk("upg_run",       bus.state, ST_RUN);

        // loss of source 0 with source 1 present
        bus.src_active = 4'b0110;
        tick(1);   chk("loss_drain",     bus.state, ST_DRAIN);
                   chk("loss_drain_sel", bus.sel_onehot, 4'b0);
        bus.mmcm_locked = 1'b0;
        tick(3);   chk("loss_drain4",    bus.sel_onehot, 4'b0);
        tick(1);   chk("loss_apply_sel", bus.sel_onehot, 4'b0010);
                   chk("loss_cnt",       bus.switch_count, 16'd3);
        tick(8);   chk("loss_wait",      bus.state, ST_WAIT);

        // reset in the middle of WAIT_LOCK
        tick(10);
        rst = 1'b1;
        tick(1);   chk("mrst_state", bus.state, ST_NOSRC);
                   chk("mrst_sel",   bus.sel_onehot, 4'b0);
                   chk("mrst_valid", bus.sel_valid, 1'b0);
                   chk("mrst_rst",   bus.mmcm_rst, 1'b1);
                   chk("mrst_cnt",   bus.switch_count, 16'd0);

        // lock timeout on source 0, fall over to source 1, then clear_fail
        bus.src_active = 4'b0011; rst = 1'b0;
        tick(5);    chk("to_apply_sel", bus.sel_onehot, 4'b0001);
        tick(8);    chk("to_wait",      bus.state, ST_WAIT);
        tick(4095); chk("to_wait_last", bus.state, ST_WAIT);
                    chk("to_fail_pre",  bus.fail_mask, 4'b0);
        tick(1);    chk("to_drain",     bus.state, ST_DRAIN);
                    chk("to_fail",      bus.fail_mask, 4'b0001);
        tick(4);    chk("to_apply1",    bus.sel_onehot, 4'b0010);
                    chk("to_cnt",       bus.switch_count, 16'd2);
        tick(8);
        bus.mmcm_locked = 1'b1;
        tick(1);    chk("to_run1",      bus.state, ST_RUN);
        bus.clear_fail = 1'b1;
        tick(1);
        bus.clear_fail = 1'b0;
                    chk("clr_fail",     bus.fail_mask, 4'b0);
                    chk("clr_keep_run", bus.state, ST_RUN);
        tick(255);  chk("clr_hold_run", bus.state, ST_RUN);
        tick(1);    chk("clr_drain",    bus.state, ST_DRAIN);
        bus.mmcm_locked = 1'b0;
        tick(4);    chk("clr_apply0",   bus.sel_onehot, 4'b0001);
                    chk("clr_cnt",      bus.switch_count, 16'd3);
        tick(8);
        bus.mmcm_locked = 1'b1;
        tick(1);    chk("clr_run0",     bus.state, ST_RUN);

        // manual selection of source 3, then fall back on its loss
        bus.manual_en = 1'b1; bus.manual_sel = 2'd3; bus.src_active = 4'b1001;
        tick(255);  chk("man_hold_run", bus.state, ST_RUN);
        tick(1);    chk("man_drain",    bus.state, ST_DRAIN);
        bus.mmcm_locked = 1'b0;
        tick(4);    chk("man_sel3",     bus.sel_onehot, 4'b1000);
                    chk("man_idx3",     bus.sel_idx, 2'd3);
        tick(8);
        bus.mmcm_locked = 1'b1;
        tick(1);    chk("man_run3",     bus.locked_out, 1'b1);
        bus.src_active = 4'b0001;
        tick(1);    chk("man_loss",     bus.state, ST_DRAIN);
        bus.mmcm_locked = 1'b0;
        tick(4);    chk("man_fb_sel",   bus.sel_onehot, 4'b0001);
                    chk("man_fb_cnt",   bus.switch_count, 16'd5);

        // all sources gone
        bus.src_active = 4'b0;
        tick(1);    chk("none_drain",   bus.state, ST_DRAIN);
        tick(4);    chk("none_nosrc",   bus.state, ST_NOSRC);
                    chk("none_rst",     bus.mmcm_rst, 1'b1);
                    chk("none_valid",   bus.sel_valid, 1'b0);

        // small instance: manual index beyond N_SRC is ignored
        bus_s.manual_en = 1'b1; bus_s.manual_sel = 2'd3; bus_s.src_active = 3'b110;
        tick(1);    chk("s_drain",      bus_s.state, ST_DRAIN);
        tick(1);    chk("s_oor_sel",    bus_s.sel_onehot, 3'b010);
                    chk("s_oor_idx",    bus_s.sel_idx, 2'd1);

        // repeated timeouts with clear_fail held: set wins, counter saturates
        bus_s.manual_en = 1'b0; bus_s.src_active = 3'b010; bus_s.clear_fail = 1'b1;
        prev_cnt = bus_s.switch_count;
        wrapped  = 1'b0;
        set_seen = 1'b0;
        for (int i = 0; i < 240; i++) begin
            tick(1);
            if (bus_s.switch_count < prev_cnt) wrapped = 1'b1;
            if (bus_s.fail_mask == 3'b010)     set_seen = 1'b1;
            prev_cnt = bus_s.switch_count;
        end
        chk("s_no_wrap",   wrapped, 1'b0);
        chk("s_cnt_sat",   bus_s.switch_count, 4'hF);
        chk("s_set_wins",  set_seen, 1'b1);

        chk("glitch_free", glitch_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
